sd_stream_deserializer: RTL and testbench
=========================================

# sd_stream_deserializer

Downstream stage of the SD-card SPI reader. Converts the reader's serial configuration bitstream (`cfg_clk`/`cfg_dat`) into WORD_W-bit words and presents them to the word FIFO over a valid/ready handshake. Also does three control jobs:
- counts delivered bits and raises `dat_done` after the image length;
- back-pressures the reader through its hold input;
- flags any word lost to overrun.

## Interface
Parameters:
- WORD_W, 16, output word width in bits; packed MSB-first.
- TOTAL_BITS, 159031792, image length in bits (19878974 bytes × 8).
- CNT_W, 32, bit-counter width; must satisfy 2^CNT_W > TOTAL_BITS.

Ports:
- clk_i  in  1  system clock (50 MHz); all logic on its rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  level; leaves IDLE when sampled high.
- cfg_clk_i  in  1  serial bit clock from the SD reader, generated in the clk_i domain; idles high.
- cfg_dat_i  in  1  serial data; valid on the cfg_clk_i rising edge.
- cfg_hold_o  out  1  registered; tells the reader to pause.
- prog_full_i  in  1  FIFO programmable-full flag.
- word_o  out  WORD_W  output word; stable while word_valid_o is high.
- word_valid_o  out  1  word_o holds an untransferred word.
- word_ready_i  in  1  FIFO can accept a word (i.e. not full).
- dat_done_o  out  1  sticky; TOTAL_BITS received and the last word transferred.
- overrun_o  out  1  sticky; a completed word was dropped.
- bit_count_o  out  CNT_W  bits accepted since leaving IDLE.
- busy_o  out  1  high in RUN or FLUSH.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- **Edge detection:** register cfg_clk_q tracks cfg_clk_i. A bit edge is cfg_clk_i=1 & cfg_clk_q=0. cfg_clk_q resets to 1, so an idle-high line never produces a false edge.
- **IDLE:** edges ignored. start_i=1 moves to RUN next cycle.
- **RUN, on each edge:**
  - shift = {shift[WORD_W-2:0], cfg_dat_i};
  - bit_count +1;
  - sub-word counter +1, wrapping at WORD_W.
- **Word completion** (edge that makes sub-word counter reach WORD_W):
  - If word_valid_o is low, or a transfer occurs that same cycle: load word_o with the full shifted value and set word_valid_o next cycle.
  - Otherwise: discard the word, set overrun_o, and leave word_o/word_valid_o untouched.
- **End of image:** the edge that makes bit_count == TOTAL_BITS goes to
  - FLUSH, if TOTAL_BITS mod WORD_W ≠ 0: the partial word is left-justified and zero-padded in the low bits, then loaded under the same rule as a full word;
  - DONE, otherwise, after the final word is loaded.
- **FLUSH / DONE:** edges ignored; bit_count_o frozen. FLUSH goes to DONE once the pending word is loaded. DONE is terminal until reset.
- **Transfer:** a transfer is word_valid_o & word_ready_i. On the next cycle word_valid_o clears unless a new word loads that same cycle.
- **dat_done_o:** set the cycle after DONE is entered with word_valid_o low, or on the cycle after the last transfer in DONE.
- **cfg_hold_o** is registered:
  - 1 in DONE and FLUSH;
  - otherwise prog_full_i | (word_valid_o & ~word_ready_i) | (sub-word counter == WORD_W-1 & word_valid_o).
- **Reset values:** all outputs 0; state IDLE; shift 0; bit_count 0; cfg_clk_q 1.

## Timing
- Latency from last bit edge to word_valid_o=1 is one clk_i cycle.
- Latency from a blocking condition to cfg_hold_o=1 is one cycle. The reader may deliver bits during that cycle, so the next word must still complete after hold rises. Only a full word completing against an occupied, unaccepted output register is an overrun.
- Coincident edge, word completion and transfer: the transfer and the load both happen; no overrun.
- start_i is ignored outside IDLE.
- Reset asserted mid-RUN immediately:
  - clears all state and outputs;
  - drops any pending word;
  - clears the sticky flags.
- At most one bit is accepted per clk_i cycle. cfg_clk_i high/low phases must each be ≥1 cycle.

## Test plan
- **Single word:** reset, start_i=1, 16 edges with bits 0xA5C3 MSB-first, word_ready_i=1 → word_valid_o pulses 1 cycle with word_o=0xA5C3; bit_count_o=16.
- **Back-pressure:** word_ready_i=0 after word 0x1234 completes → cfg_hold_o=1 within 1 cycle. Feed 15 more bits, then raise ready → 0x1234 transfers, the next word completes, overrun_o stays 0.
- **Overrun:** word_ready_i held 0 while 32 bits arrive → first word retained in word_o, overrun_o=1 sticky, second word lost.
- **Partial flush:** TOTAL_BITS=20, bits 0xFFFFF → words 0xFFFF then 0xF000. dat_done_o=1 after the second transfer; further edges leave bit_count_o=20.
- **prog_full:** prog_full_i=1 in RUN with no pending word → cfg_hold_o=1 next cycle. prog_full_i=0 → cfg_hold_o=0 next cycle.
- **Reset mid-run:** reset_n_i=0 after 7 bits → all outputs 0, state IDLE. After release, edges are ignored until start_i.

Source files
------------

// File: rtl/sd_stream_deserializer.sv
// Serial-to-parallel stage behind the SD-card SPI reader: packs cfg_dat_i bits MSB-first
// into WORD_W-bit words, hands them off over valid/ready, and tracks image length and overruns.
module sd_stream_deserializer #(
    parameter int WORD_W     = 16,
    parameter int TOTAL_BITS = 159031792,
    parameter int CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              cfg_clk_i,
    input  logic              cfg_dat_i,
    output logic              cfg_hold_o,
    input  logic              prog_full_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic              dat_done_o,
    output logic              overrun_o,
    output logic [CNT_W-1:0]  bit_count_o,
    output logic              busy_o
);

    localparam int SUB_W                    = $clog2(WORD_W) + 1;
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] TOTAL_CNT  = CNT_W'(TOTAL_BITS);
    localparam logic             HAS_TAIL   = (TOTAL_BITS % WORD_W) != 0;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t             state, state_next;
    logic               cfg_clk_q;
    logic [WORD_W-1:0]  shift, shift_next, shifted;
    logic [SUB_W-1:0]   sub_cnt, sub_next;
    logic [CNT_W-1:0]   bit_count, count_next;
    logic [WORD_W-1:0]  word, word_next;
    logic               word_valid, valid_next;
    logic               overrun, overrun_next;
    logic               dat_done, done_next;
    logic               cfg_hold, hold_next;
    logic               bit_edge, xfer, can_load;

    // Move the n received tail bits to the top of the word, zero-filling below.
    function automatic logic [WORD_W-1:0] left_justify(input logic [WORD_W-1:0] bits,
                                                       input logic [SUB_W-1:0]  n);
        return bits << (SUB_W'(WORD_W) - n);
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        bit_edge     = cfg_clk_i & ~cfg_clk_q;
        xfer         = word_valid & word_ready_i;
        can_load     = ~word_valid | xfer;
        shifted      = {shift[WORD_W-2:0], cfg_dat_i};
        state_next   = state;
        shift_next   = shift;
        sub_next     = sub_cnt;
        count_next   = bit_count;
        word_next    = word;
        valid_next   = word_valid & ~word_ready_i;
        overrun_next = overrun;
        done_next    = dat_done;
        case (state)
            IDLE: begin
                if (start_i) state_next = RUN;
            end
            RUN: begin
                if (bit_edge) begin
                    shift_next = shifted;
                    count_next = bit_count + CNT_W'(1);
                    sub_next   = (sub_cnt == SUB_LAST) ? '0 : sub_cnt + SUB_W'(1);
                    if (sub_cnt == SUB_LAST) begin
                        if (can_load) begin
                            word_next  = shifted;
                            valid_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                    end
                    if (count_next == TOTAL_CNT) state_next = HAS_TAIL ? FLUSH : DONE;
                end
            end
            FLUSH: begin
                // sub_cnt holds the tail length here, always nonzero
                if (can_load) begin
                    word_next  = left_justify(shift, sub_cnt);
                    valid_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (can_load) done_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        hold_next = (state == FLUSH) || (state == DONE) || prog_full_i ||
                    (word_valid && !word_ready_i) || (sub_cnt == SUB_LAST && word_valid);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cfg_clk_q  <= 1'b1;
            shift      <= '0;
            sub_cnt    <= '0;
            bit_count  <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
            dat_done   <= 1'b0;
            cfg_hold   <= 1'b0;
        end else begin
            cfg_clk_q  <= cfg_clk_i;
            shift      <= shift_next;
            sub_cnt    <= sub_next;
            bit_count  <= count_next;
            word       <= word_next;
            word_valid <= valid_next;
            overrun    <= overrun_next;
            dat_done   <= done_next;
            cfg_hold   <= hold_next;
        end
    end

    assign word_o       = word;
    assign word_valid_o = word_valid;
    assign overrun_o    = overrun;
    assign dat_done_o   = dat_done;
    assign cfg_hold_o   = cfg_hold;
    assign bit_count_o  = bit_count;
    assign busy_o       = (state == RUN) || (state == FLUSH);

endmodule

// File: tb/tb_sd_stream_deserializer.sv
// Directed bench: dut_a has a 64-bit image (word multiple), dut_b a 20-bit image (tail flush).
module tb_sd_stream_deserializer;

    logic        clk = 1'b0;
    logic        reset_n, start, cfg_clk, cfg_dat, prog_full, ready;
    logic        a_hold, a_valid, a_done, a_overrun, a_busy;
    logic [15:0] a_word;
    logic [31:0] a_count;
    logic        b_hold, b_valid, b_done, b_overrun, b_busy;
    logic [15:0] b_word;
    logic [31:0] b_count;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    sd_stream_deserializer #(.WORD_W(16), .TOTAL_BITS(64), .CNT_W(32)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .cfg_clk_i(cfg_clk),
        .cfg_dat_i(cfg_dat), .cfg_hold_o(a_hold), .prog_full_i(prog_full),
        .word_o(a_word), .word_valid_o(a_valid), .word_ready_i(ready),
        .dat_done_o(a_done), .overrun_o(a_overrun), .bit_count_o(a_count), .busy_o(a_busy));

    sd_stream_deserializer #(.WORD_W(16), .TOTAL_BITS(20), .CNT_W(32)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .cfg_clk_i(cfg_clk),
        .cfg_dat_i(cfg_dat), .cfg_hold_o(b_hold), .prog_full_i(prog_full),
        .word_o(b_word), .word_valid_o(b_valid), .word_ready_i(ready),
        .dat_done_o(b_done), .overrun_o(b_overrun), .bit_count_o(b_count), .busy_o(b_busy));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        cfg_clk   = 1'b1;
        cfg_dat   = 1'b0;
        prog_full = 1'b0;
        ready     = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        cfg_dat = b;
        cfg_clk = 1'b0;
        @(negedge clk);
        cfg_clk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_range(input logic [15:0] val, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(val[i]);
    endtask

    initial begin
        // reset state
        reset_n = 1'b0; start = 1'b0; cfg_clk = 1'b1; cfg_dat = 1'b0;
        prog_full = 1'b0; ready = 1'b0;
        #1;
        check_val("rst_word",  32'(a_word), 32'h0);
        check_val("rst_flags", {27'd0, a_valid, a_hold, a_done, a_overrun, a_busy}, 32'h0);
        check_val("rst_count", a_count, 32'h0);
        do_reset();

        // single word, streaming
        ready = 1'b1;
        do_start();
        check_val("sw_busy", 32'(a_busy), 32'h1);
        send_range(16'hA5C3, 15, 0);
        check_val("sw_valid", 32'(a_valid), 32'h1);
        check_val("sw_word",  32'(a_word), 32'hA5C3);
        check_val("sw_count", a_count, 32'd16);
        @(negedge clk);
        check_val("sw_pulse", 32'(a_valid), 32'h0);

        // back-pressure, then coincident completion + transfer
        do_reset();
        do_start();
        send_range(16'h1234, 15, 0);
        check_val("bp_word", 32'(a_word), 32'h1234);
        @(negedge clk);
        check_val("bp_hold", 32'(a_hold), 32'h1);
        send_range(16'h5678, 15, 1);
        check_val("bp_keep", 32'(a_word), 32'h1234);
        ready = 1'b1;
        @(negedge clk);
        check_val("bp_xfer", 32'(a_valid), 32'h0);
        send_range(16'h5678, 0, 0);
        check_val("bp_word2", 32'(a_word), 32'h5678);
        check_val("bp_valid2", 32'(a_valid), 32'h1);
        ready = 1'b0;
        send_range(16'h9ABC, 15, 1);
        check_val("bp_keep2", 32'(a_word), 32'h5678);
        cfg_dat = 1'b0;
        cfg_clk = 1'b0;
        @(negedge clk);
        cfg_clk = 1'b1;
        ready   = 1'b1;
        @(negedge clk);
        check_val("co_word",  32'(a_word), 32'h9ABC);
        check_val("co_valid", 32'(a_valid), 32'h1);
        check_val("co_ovr",   32'(a_overrun), 32'h0);
        check_val("co_count", a_count, 32'd48);

        // overrun
        do_reset();
        do_start();
        send_range(16'hCAFE, 15, 0);
        send_range(16'hBEEF, 15, 0);
        check_val("ov_word",  32'(a_word), 32'hCAFE);
        check_val("ov_valid", 32'(a_valid), 32'h1);
        check_val("ov_flag",  32'(a_overrun), 32'h1);
        check_val("ov_count", a_count, 32'd32);
        ready = 1'b1;
        @(negedge clk);
        check_val("ov_drain",  32'(a_valid), 32'h0);
        check_val("ov_sticky", 32'(a_overrun), 32'h1);

        // image ending on a word boundary
        do_reset();
        ready = 1'b1;
        do_start();
        send_range(16'h0001, 15, 0);
        send_range(16'h0002, 15, 0);
        send_range(16'h0003, 15, 0);
        send_range(16'h8000, 15, 0);
        check_val("dn_word",  32'(a_word), 32'h8000);
        check_val("dn_early", 32'(a_done), 32'h0);
        check_val("dn_busy",  32'(a_busy), 32'h0);
        @(negedge clk);
        check_val("dn_done",  32'(a_done), 32'h1);
        send_range(16'hFFFF, 1, 0);
        check_val("dn_count", a_count, 32'd64);
        check_val("dn_hold",  32'(a_hold), 32'h1);

        // partial tail flush
        do_reset();
        ready = 1'b1;
        do_start();
        send_range(16'hFFFF, 15, 0);
        check_val("fl_word1", 32'(b_word), 32'hFFFF);
        send_range(16'h000F, 3, 0);
        check_val("fl_count", b_count, 32'd20);
        check_val("fl_busy",  32'(b_busy), 32'h1);
        @(negedge clk);
        check_val("fl_word2", 32'(b_word), 32'hF000);
        check_val("fl_valid", 32'(b_valid), 32'h1);
        check_val("fl_early", 32'(b_done), 32'h0);
        @(negedge clk);
        check_val("fl_done",  32'(b_done), 32'h1);
        send_range(16'h0007, 2, 0);
        check_val("fl_frozen", b_count, 32'd20);

        // prog_full hold, then reset mid-run
        do_reset();
        do_start();
        @(negedge clk);
        check_val("pf_idle", 32'(a_hold), 32'h0);
        prog_full = 1'b1;
        @(negedge clk);
        check_val("pf_on", 32'(a_hold), 32'h1);
        prog_full = 1'b0;
        @(negedge clk);
        check_val("pf_off", 32'(a_hold), 32'h0);
        send_range(16'h007F, 6, 0);
        check_val("mr_count", a_count, 32'd7);
        prog_full = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("mr_count0", a_count, 32'h0);
        check_val("mr_flags", {27'd0, a_valid, a_hold, a_done, a_overrun, a_busy}, 32'h0);
        prog_full = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_range(16'h0005, 2, 0);
        check_val("mr_ignored", a_count, 32'h0);
        check_val("mr_idle", 32'(a_busy), 32'h0);
        do_start();
        send_bit(1'b1);
        check_val("mr_restart", a_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
